// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase controller.
// Holds the phase encoding reported on the phase output and the
// {Red, Yellow, Green} signal-head codes.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_AG      = 3'd0,
        PH_AY      = 3'd1,
        PH_BG      = 3'd2,
        PH_BY      = 3'd3,
        PH_ALL_RED = 3'd4
    } phase_e;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    // Road A head for a given phase.
    function automatic logic [2:0] head_a(phase_e p);
        case (p)
            PH_AG:   return GREEN;
            PH_AY:   return YELLOW;
            default: return RED;
        endcase
    endfunction

    // Road B head for a given phase.
    function automatic logic [2:0] head_b(phase_e p);
        case (p)
            PH_BG:   return GREEN;
            PH_BY:   return YELLOW;
            default: return RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_ped_latch.sv
// Pedestrian request latch: a set pulse makes the request pending until
// the walk phase is granted. When set and clear coincide, clear wins
// because the walk is being granted on that same edge.
module traffic_ped_latch (
    input  logic clk,
    input  logic rstn,
    input  logic set_i,
    input  logic clear_i,
    output logic pend_o
);

    // Pending flag with clear priority over set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        pend_o <= 1'b0;
        else if (clear_i) pend_o <= 1'b0;
        else if (set_i)   pend_o <= 1'b1;
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase scheduler.
// Sequences AG -> AY -> BG -> BY with emergency preemption into ALL_RED.
// Optional feature macro: TRAFFIC_PED_EN enables pedestrian latches,
// early green termination and the walk outputs; without it the walk
// outputs are tied low and greens always run their full duration.
module traffic_phase_ctrl #(
    parameter int unsigned GREEN_A   = 8,
    parameter int unsigned GREEN_B   = 10,
    parameter int unsigned YELLOW    = 3,
    parameter int unsigned MIN_GREEN = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ped_req_a,
    input  logic       ped_req_b,
    input  logic       emg_req,
    output logic [2:0] lightA,
    output logic [2:0] lightB,
    output logic       walk_a,
    output logic       walk_b,
    output logic       emg_ack,
    output logic [2:0] phase
);

    import traffic_pkg::*;

    localparam logic [CNT_W-1:0] GA_C  = CNT_W'(GREEN_A);
    localparam logic [CNT_W-1:0] GB_C  = CNT_W'(GREEN_B);
    localparam logic [CNT_W-1:0] Y_C   = CNT_W'(YELLOW);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    phase_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cut_a, cut_b;   // pedestrian early termination of A/B green

`ifdef TRAFFIC_PED_EN
    logic pend_a, pend_b;
    logic clr_a, clr_b;

    // A pending request is served when its walk phase is entered.
    assign clr_a = (state_d == PH_BG) && (state_q != PH_BG);
    assign clr_b = (state_d == PH_AG) && (state_q != PH_AG);

    traffic_ped_latch u_ped_a (
        .clk     (clk),
        .rstn    (rstn),
        .set_i   (ped_req_a),
        .clear_i (clr_a),
        .pend_o  (pend_a)
    );

    traffic_ped_latch u_ped_b (
        .clk     (clk),
        .rstn    (rstn),
        .set_i   (ped_req_b),
        .clear_i (clr_b),
        .pend_o  (pend_b)
    );

    // The latch is registered, so a request affects the green one edge later.
    assign cut_a = pend_a && (cnt_q >= MIN_C);
    assign cut_b = pend_b && (cnt_q >= MIN_C);

    // Walk signals follow the next phase so they switch with the heads.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            walk_a <= 1'b0;
            walk_b <= 1'b1;
        end else begin
            walk_a <= (state_d == PH_BG);
            walk_b <= (state_d == PH_AG);
        end
    end
`else
    logic unused_ped;

    assign unused_ped = ped_req_a ^ ped_req_b;
    assign cut_a      = 1'b0;
    assign cut_b      = 1'b0;
    assign walk_a     = 1'b0;
    assign walk_b     = 1'b0;
`endif

    // Next-phase decode: emergency, then pedestrian cut, then timer.
    always_comb begin
        // NOTE: defaulting state_d first keeps every path assigned, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            PH_AG:      if (emg_req || cut_a || cnt_q == GA_C) state_d = PH_AY;
            PH_AY:      if (cnt_q == Y_C) state_d = emg_req ? PH_ALL_RED : PH_BG;
            PH_BG:      if (emg_req || cut_b || cnt_q == GB_C) state_d = PH_BY;
            PH_BY:      if (cnt_q == Y_C) state_d = emg_req ? PH_ALL_RED : PH_AG;
            PH_ALL_RED: if (!emg_req) state_d = PH_AG;
            default:    state_d = PH_AG;
        endcase
    end

    // Counter restarts at 1 on phase entry; saturates during a long ALL_RED.
    always_comb begin
        if (state_d != state_q) cnt_d = ONE;
        else if (cnt_q != '1)   cnt_d = cnt_q + ONE;
        else                    cnt_d = cnt_q;
    end

    // State, counter and head outputs all load from the next-phase decode.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rstn) begin
            state_q <= PH_AG;
            cnt_q   <= ONE;
            lightA  <= head_a(PH_AG);
            lightB  <= head_b(PH_AG);
            emg_ack <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lightA  <= head_a(state_d);
            lightB  <= head_b(state_d);
            emg_ack <= (state_d == PH_ALL_RED);
        end
    end

    assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl. The stimulus process steps a
// phase/age reference model and queues the expected outputs; a monitor
// pops and compares one entry after every rising edge.
module tb_traffic_phase_ctrl;

    localparam int GREEN_A   = 8;
    localparam int GREEN_B   = 10;
    localparam int YELLOW    = 3;
    localparam int MIN_GREEN = 4;
`ifdef TRAFFIC_PED_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] ph;
        logic [2:0] la;
        logic [2:0] lb;
        logic       wa;
        logic       wb;
        logic       ack;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       ped_req_a = 1'b0;
    logic       ped_req_b = 1'b0;
    logic       emg_req = 1'b0;
    logic [2:0] lightA, lightB, phase;
    logic       walk_a, walk_b, emg_ack;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    // Reference model: current phase (0..4), cycles spent in it, pending flags.
    int m_phase;
    int m_age;
    bit m_pa, m_pb;

    traffic_phase_ctrl #(
        .GREEN_A(GREEN_A), .GREEN_B(GREEN_B), .YELLOW(YELLOW),
        .MIN_GREEN(MIN_GREEN), .CNT_W(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .ped_req_a(ped_req_a), .ped_req_b(ped_req_b), .emg_req(emg_req),
        .lightA(lightA), .lightB(lightB),
        .walk_a(walk_a), .walk_b(walk_b),
        .emg_ack(emg_ack), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int dur(input int p);
        case (p)
            0:       return GREEN_A;
            2:       return GREEN_B;
            default: return YELLOW;
        endcase
    endfunction

    function automatic exp_t expect_of(input int p);
        exp_t e;
        e.ph  = 3'(p);
        e.la  = (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
        e.lb  = (p == 2) ? 3'b001 : (p == 3) ? 3'b010 : 3'b100;
        e.wa  = PED_EN && (p == 2);
        e.wb  = PED_EN && (p == 0);
        e.ack = (p == 4);
        return e;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_age   = 1;
        m_pa    = 1'b0;
        m_pb    = 1'b0;
    endtask

    // Effect of one rising edge given the inputs sampled on it.
    task automatic model_step(input bit pa, input bit pb, input bit emg);
        int nxt;
        bit want;
        nxt = m_phase;
        if (m_phase == 4) begin
            if (!emg) nxt = 0;
        end else if (m_phase % 2 == 0) begin
            want = (m_phase == 0) ? m_pa : m_pb;
            if (emg || (PED_EN && want && m_age >= MIN_GREEN) || m_age == dur(m_phase))
                nxt = m_phase + 1;
        end else if (m_age == dur(m_phase)) begin
            nxt = emg ? 4 : (m_phase + 1) % 4;
        end
        if (PED_EN) begin
            m_pa = m_pa | pa;
            m_pb = m_pb | pb;
        end
        if (nxt != m_phase) begin
            if (nxt == 2) m_pa = 1'b0;
            if (nxt == 0) m_pb = 1'b0;
            m_age = 1;
        end else begin
            m_age++;
        end
        m_phase = nxt;
    endtask

    // One cycle of stimulus: drive at the falling edge, queue the expectation.
    task automatic drive(input bit pa, input bit pb, input bit emg);
        @(negedge clk);
        ped_req_a = pa;
        ped_req_b = pb;
        emg_req   = emg;
        model_step(pa, pb, emg);
        sb_q.push_back(expect_of(m_phase));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_lightA"},  lightA,  3'b001);
        check({tag, "_lightB"},  lightB,  3'b100);
        check({tag, "_walk_a"},  walk_a,  1'b0);
        check({tag, "_walk_b"},  walk_b,  PED_EN);
        check({tag, "_emg_ack"}, emg_ack, 1'b0);
        check({tag, "_phase"},   phase,   3'd0);
    endtask

    // Asynchronous reset pulse placed mid-cycle, spanning one rising edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rstn      = 1'b0;
        ped_req_a = 1'b0;
        ped_req_b = 1'b0;
        emg_req   = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    // Monitor: every rising edge the DUT presents a new phase word.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("phase",   phase,   e.ph);
                check("lightA",  lightA,  e.la);
                check("lightB",  lightB,  e.lb);
                check("walk_a",  walk_a,  e.wa);
                check("walk_b",  walk_b,  e.wb);
                check("emg_ack", emg_ack, e.ack);
            end
        end
    end

    initial begin
        bit emg_on;
        int n_rst;
        emg_on = 1'b0;
        n_rst  = 0;
        model_reset();

        // Values while reset is held, then release away from any edge.
        #12;
        check_reset_values("por");
        @(posedge clk);
        #2;
        rstn = 1'b1;

        // Free-running fixed plan past one full 24-cycle round.
        for (int i = 0; i < 30; i++) drive(0, 0, 0);

        // Pedestrian A request on the first AG cycle after reset.
        do_reset("rst1");
        drive(1, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 0, 0);

        // Pedestrian A request at AG cnt=6.
        for (int i = 0; i < 40 && !(m_phase == 0 && m_age == 6); i++) drive(0, 0, 0);
        drive(1, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0);

        // Emergency from AG cnt=3, held 5 cycles into ALL_RED.
        for (int i = 0; i < 40 && !(m_phase == 0 && m_age == 3); i++) drive(0, 0, 0);
        for (int i = 0; i < 20 && m_phase != 4; i++) drive(0, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0);

        // Emergency rising at AY cnt=2.
        for (int i = 0; i < 40 && !(m_phase == 1 && m_age == 2); i++) drive(0, 0, 0);
        for (int i = 0; i < 10 && m_phase != 4; i++) drive(0, 0, 1);
        drive(0, 0, 1);
        drive(0, 0, 0);

        // Reset mid-BG with a pending B request.
        for (int i = 0; i < 40 && !(m_phase == 2 && m_age == 2); i++) drive(0, 0, 0);
        drive(0, 1, 0);
        drive(0, 0, 0);
        do_reset("rst_bg");
        for (int i = 0; i < 30; i++) drive(0, 0, 0);

        // Randomized mix of pedestrian pulses and emergency episodes.
        for (int i = 0; i < 2000; i++) begin
            if (m_phase == 2 && m_age == 5 && (m_pb || !PED_EN) && n_rst < 4) begin
                do_reset("rst_rnd");
                n_rst++;
            end
            if (!emg_on) emg_on = ($urandom_range(0, 39) == 0);
            else         emg_on = ($urandom_range(0, 7) != 0);
            drive($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, emg_on);
        end

        @(posedge clk);
        #2;
        check("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Phase scheduler for a two-road intersection. It sequences the A/B signal heads through green, yellow and red and arbitrates between three sources: the fixed-time plan, latched pedestrian crossing requests (which shorten the conflicting green) and an emergency preemption request (which forces all-red). It drives the signal heads directly and reports the current phase to the intersection status logic.

## Interface
- GREEN_A, 8, A-green duration in cycles
- GREEN_B, 10, B-green duration in cycles
- YELLOW, 3, yellow duration in cycles (both roads)
- MIN_GREEN, 4, minimum green before a pedestrian request may cut it short
- CNT_W, 4, phase counter width; every duration is in 1..2^CNT_W-1 and MIN_GREEN ≤ min(GREEN_A, GREEN_B)
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- ped_req_a  input  1  pulse: pedestrian wants to cross road A
- ped_req_b  input  1  pulse: pedestrian wants to cross road B
- emg_req  input  1  level: emergency preemption
- lightA  output  3  road A head, {Red, Yellow, Green}
- lightB  output  3  road B head, {Red, Yellow, Green}
- walk_a  output  1  walk signal for crossing road A
- walk_b  output  1  walk signal for crossing road B
- emg_ack  output  1  high while in ALL_RED
- phase  output  3  AG=0, AY=1, BG=2, BY=3, ALL_RED=4

## Operation
- States: AG (A=001, B=100), AY (A=010, B=100), BG (A=100, B=001), BY (A=100, B=010), ALL_RED (both 100).
- Phase counter cnt starts at 1 on phase entry and increments every cycle. The phase ends on the cycle where cnt equals its duration, then the next phase is entered with cnt=1.
- Fixed plan: AG→AY→BG→BY→AG. A full cycle is 24 cycles with the default parameters.
- Pedestrian latches: a ped_req_x pulse sets pend_x. pend_a clears on entry to BG; pend_b clears on entry to AG. If a set and a clear occur on the same cycle, the clear wins, because the walk is granted in that phase.
- Early termination: in AG, if pend_a=1 and cnt ≥ MIN_GREEN, go to AY. The BG/pend_b case is symmetric.
- walk_a=1 exactly while in BG. walk_b=1 exactly while in AG.
- Priority in green phases: emg_req, then pedestrian early termination, then timer.
- Emergency:
  - If emg_req is sampled high in AG or BG, go to the matching yellow next cycle with cnt=1.
  - A yellow phase always runs its full YELLOW cycles, even with emg_req active. On completion it goes to ALL_RED if emg_req=1; otherwise it follows the normal plan.
  - ALL_RED holds while emg_req=1. When emg_req is sampled low, go to AG with cnt=1.
  - walk outputs are 0 in ALL_RED. Pending latches are retained.
- Reset values: state AG, cnt=1, pend_a=pend_b=0, lightA=001, lightB=100, walk_a=0, walk_b=1, emg_ack=0, phase=0.

## Timing
- All outputs are registered and loaded from the next-state decode. They therefore change on the same edge as the state register, with zero lag versus phase.
- Pedestrian request to effect:
  - A pulse sampled at edge k sets pend at k.
  - Early termination is evaluated from cycle k+1 onward.
- Emergency latency from a green phase: emg_req sampled at edge k puts the head in yellow at k, then all-red after YELLOW cycles.
- ALL_RED lasts at least 1 cycle.
- Reset assertion mid-phase immediately forces all reset values. The first phase after release is a full AG.

## Configuration
- TRAFFIC_PED_EN defined: pedestrian latches, early termination and walk outputs behave as described.
- TRAFFIC_PED_EN undefined:
  - ped_req_a and ped_req_b are ignored.
  - walk_a and walk_b are tied to 0, including during reset.
  - Greens always run full duration.
  - Ports are unchanged.

## Structure
- traffic_pkg holds:
  - the phase enum (AG..ALL_RED, 3 bits)
  - the light constants RED=3'b100, YELLOW=3'b010, GREEN=3'b001
- Sub-module traffic_ped_latch (set, clear, pend; clear-wins) is instantiated twice and only under TRAFFIC_PED_EN.

## Test plan
- No requests after reset → AG 8 cycles, AY 3, BG 10, BY 3, back to AG at cycle 24, with light codes as listed.
- ped_req_a pulse at AG cnt=1 → AG ends after 4 cycles, then AY 3, then BG with walk_a=1 for 10 cycles, and pend_a is clear.
- ped_req_a pulse at AG cnt=6 → AY entered on the next edge.
- emg_req rises at AG cnt=3 and is held 5 cycles after all-red is reached → AY 3 cycles, ALL_RED with emg_ack=1 and lights 100/100 while held, then AG cnt=1 one edge after the drop.
- emg_req rises at AY cnt=2 → yellow completes at cnt=3, then ALL_RED.
- rstn pulsed low mid-BG with pend_b=1 → lights immediately 001/100, walk_a=0, walk_b=1, pend_b=0, phase=0.
